lv_ctrl_fsm_gen: RTL and testbench
==================================

Name: lv_ctrl_fsm_gen

Overview:
Parametrised next-generation LV control FSM with ERR_NUM generic error inputs.
- Per-error debounce, runtime mask, and a hard/soft class split that decides whether failsafe is blocked.
- Fault-retry counting with a LOCK state, and an efuse-load handshake with timeout.
- Sits between the register/error collectors and the PWM/failsafe/SPI enables, replacing the fixed-error control unit.

Parameters:
ERR_NUM, 16, number of error inputs (1..32)
ERR_HARD_MSK, 16'h00FF, bit=1: error is hard (blocks failsafe, forces FAULT)
DBNC_CYC, 4, consecutive cycles to assert/deassert a qualified error (>=1)
RECOV_CYC, 32, error-free cycles in FAULT before return to NML
RETRY_MAX, 3, fault entries before LOCK (1..15)
EFUSE_TMO_CYC, 1024, max cycles of o_efuse_load_req before timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_pwr_on  in  1  supply good
i_err  in  ERR_NUM  raw error levels
i_err_mask  in  ERR_NUM  1 = ignore error
i_err_clr  in  ERR_NUM  write-1 pulse, clears sticky bits
i_fsenb_n  in  1  failsafe request, active low
i_nml_en  in  1  permission to leave WAIT
i_cfg_en  in  1  config request
i_efuse_vld  in  1  efuse data valid
o_efuse_load_req  out  1  efuse load request
i_efuse_load_done  in  1  efuse load complete pulse
o_pwm_en  out  1  PWM enable
o_fsc_en  out  1  failsafe control enable
o_intb_n  out  1  interrupt, active low
o_err_qual  out  ERR_NUM  debounced, unmasked errors
o_err_sticky  out  ERR_NUM  latched qualified errors
o_retry_cnt  out  4  fault-entry count
o_efuse_tmo  out  1  sticky efuse timeout flag
o_cur_st  out  CTRL_FSM_ST_W  current state

Behaviour:
Reset values:
- State PWR_DWN_ST; o_intb_n=1; all other outputs 0.

Debounce and error classes:
- Per bit: a counter of width $clog2(DBNC_CYC+1) counts cycles where raw differs from filtered; filtered toggles when count==DBNC_CYC-1; any agreement resets the counter.
- o_err_qual = filtered & ~i_err_mask.
- Register-to-qual latency is DBNC_CYC cycles.
- hard = qual & ERR_HARD_MSK; soft = qual & ~ERR_HARD_MSK.

Sticky errors:
- o_err_sticky |= qual each cycle.
- i_err_clr clears per bit; set wins over a simultaneous clr.

State transitions:
- ~i_pwr_on in any state -> PWR_DWN_ST next cycle; highest priority.
- PWR_DWN: i_pwr_on -> WAIT.
- WAIT:
  - o_efuse_tmo -> LOCK.
  - Else if i_efuse_vld & i_nml_en & ~|hard: ~i_fsenb_n -> FAILSAFE, else -> NML.
- NML, priority order:
  - i_cfg_en -> CFG.
  - |hard -> FAULT.
  - ~i_fsenb_n -> FAILSAFE.
  - |soft -> FAULT.
- FAILSAFE: |hard -> FAULT; else i_fsenb_n -> NML.
- FAULT, priority order:
  - i_cfg_en -> CFG.
  - retry_cnt==RETRY_MAX -> LOCK.
  - ~|hard & ~i_fsenb_n -> FAILSAFE.
  - recov_done & i_fsenb_n -> NML.
- CFG: ~i_cfg_en -> FAULT.
- LOCK: exit only via ~i_pwr_on.
- Illegal encoding -> PWR_DWN.

Counters:
- recov_cnt counts consecutive cycles in FAULT with qual==0; it resets on any qual bit or on leaving FAULT.
- recov_done = (recov_cnt==RECOV_CYC-1).
- retry_cnt increments (saturating at RETRY_MAX) on each NML/FAILSAFE->FAULT transition.
- retry_cnt clears on CFG entry and in PWR_DWN.

Efuse handshake:
- In WAIT with ~i_efuse_vld: set req; clear on i_efuse_load_done (done wins if simultaneous).
- Timeout counter runs while req=1; at EFUSE_TMO_CYC, set o_efuse_tmo (cleared only by reset or PWR_DWN) and drop req.
- Leaving WAIT drops req.

Outputs:
- All enables are registered from next state, so they assert in the same cycle o_cur_st changes.
- o_pwm_en = nxt==NML.
- o_fsc_en = nxt==FAILSAFE.
- o_intb_n = 0 when nxt is PWR_DWN, WAIT, FAULT or LOCK, or when nxt==CFG & |o_err_sticky.

Optional Feature:
LV_CTRL_FIRST_ERR_EN:
- Defined: adds o_first_err_idx ($clog2(ERR_NUM) bits) and o_first_err_vld.
- On the first qual rising edge while o_first_err_vld=0, capture the lowest set index.
- Cleared on CFG exit or PWR_DWN.
- Undefined: ports and logic absent.

Decomposition:
- lv_ctrl_pkg holds:
  - the state enum (PWR_DWN_ST, WAIT_ST, NML_ST, FAILSAFE_ST, FAULT_ST, CFG_ST, LOCK_ST);
  - CTRL_FSM_ST_W=3;
  - RETRY_CNT_W=4.
- Sub-module lv_err_dbnc (parameter DBNC_CYC) is instantiated ERR_NUM times via generate.

Test Plan:
- Power-up: pwr_on=1, efuse_vld=1, nml_en=1, fsenb_n=1, no errors -> WAIT then NML; pwm_en=1, intb_n=1.
- Debounce: soft err bit 9 high 3 cycles -> no change; high 4 cycles -> qual[9]=1, FAULT, pwm_en=0, retry_cnt=1.
- Recovery: clear err -> after 4 debounce + 32 cycles -> NML.
- LOCK: three NML->FAULT entries -> retry_cnt=3, then LOCK; only pwr_on=0 exits to PWR_DWN.
- Failsafe: fsenb_n=0 with soft err in NML -> FAILSAFE, fsc_en=1; then hard err bit 2 -> FAULT.
- Efuse: efuse_vld=0, no done for 1024 cycles -> req drops, o_efuse_tmo=1, LOCK.
- Masking: err_mask[2]=1 with hard err bit 2 -> qual=0, state remains NML.

Source files
------------

// File: rtl/lv_ctrl_pkg.sv
// rtl/lv_ctrl_pkg.sv - shared state encoding and widths for the LV control FSM
package lv_ctrl_pkg;

    localparam int CTRL_FSM_ST_W = 3;
    localparam int RETRY_CNT_W   = 4;

    typedef enum logic [CTRL_FSM_ST_W-1:0] {
        PWR_DWN_ST  = 3'd0,
        WAIT_ST     = 3'd1,
        NML_ST      = 3'd2,
        FAILSAFE_ST = 3'd3,
        FAULT_ST    = 3'd4,
        CFG_ST      = 3'd5,
        LOCK_ST     = 3'd6
    } ctrl_st_e;

    // States that always hold the interrupt line active, independent of error history
    function automatic logic st_forces_int(input ctrl_st_e st);
        return (st == PWR_DWN_ST) || (st == WAIT_ST) || (st == FAULT_ST) || (st == LOCK_ST);
    endfunction

endpackage

// File: rtl/lv_err_dbnc.sv
// rtl/lv_err_dbnc.sv - single-bit symmetric debounce filter
module lv_err_dbnc #(
    parameter int DBNC_CYC = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_filt
);

    localparam int               CNT_W    = $clog2(DBNC_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Count consecutive samples that disagree with the filtered level; flip on the last one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_raw == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_filt <= i_raw;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/lv_ctrl_fsm_gen.sv
// rtl/lv_ctrl_fsm_gen.sv - LV control FSM top; define LV_CTRL_FIRST_ERR_EN for first-error capture
module lv_ctrl_fsm_gen
    import lv_ctrl_pkg::*;
#(
    parameter int          ERR_NUM       = 16,
    parameter logic [31:0] ERR_HARD_MSK  = 32'h0000_00FF,
    parameter int          DBNC_CYC      = 4,
    parameter int          RECOV_CYC     = 32,
    parameter int          RETRY_MAX     = 3,
    parameter int          EFUSE_TMO_CYC = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pwr_on,
    input  logic [ERR_NUM-1:0]       i_err,
    input  logic [ERR_NUM-1:0]       i_err_mask,
    input  logic [ERR_NUM-1:0]       i_err_clr,
    input  logic                     i_fsenb_n,
    input  logic                     i_nml_en,
    input  logic                     i_cfg_en,
    input  logic                     i_efuse_vld,
    output logic                     o_efuse_load_req,
    input  logic                     i_efuse_load_done,
    output logic                     o_pwm_en,
    output logic                     o_fsc_en,
    output logic                     o_intb_n,
    output logic [ERR_NUM-1:0]       o_err_qual,
    output logic [ERR_NUM-1:0]       o_err_sticky,
    output logic [RETRY_CNT_W-1:0]   o_retry_cnt,
    output logic                     o_efuse_tmo,
    output logic [CTRL_FSM_ST_W-1:0] o_cur_st
`ifdef LV_CTRL_FIRST_ERR_EN
    ,
    output logic [((ERR_NUM > 1) ? $clog2(ERR_NUM) : 1)-1:0] o_first_err_idx,
    output logic                                             o_first_err_vld
`endif
);

    localparam int                     RC_W       = $clog2(RECOV_CYC + 1);
    localparam logic [RC_W-1:0]        RECOV_LAST = RC_W'(RECOV_CYC - 1);
    localparam int                     TC_W       = $clog2(EFUSE_TMO_CYC + 1);
    localparam logic [TC_W-1:0]        TMO_LAST   = TC_W'(EFUSE_TMO_CYC - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIM  = RETRY_CNT_W'(RETRY_MAX);
    localparam logic [ERR_NUM-1:0]     HARD_MSK   = ERR_HARD_MSK[ERR_NUM-1:0];

    ctrl_st_e               r_state;
    ctrl_st_e               w_nxt;
    logic [ERR_NUM-1:0]     w_filt;
    logic [ERR_NUM-1:0]     w_qual;
    logic [ERR_NUM-1:0]     w_hard;
    logic [ERR_NUM-1:0]     w_soft;
    logic [ERR_NUM-1:0]     r_sticky;
    logic [RC_W-1:0]        r_recov_cnt;
    logic                   w_recov_done;
    logic [RETRY_CNT_W-1:0] r_retry;
    logic                   r_req;
    logic                   r_tmo;
    logic [TC_W-1:0]        r_tmo_cnt;
    logic                   w_tmo_hit;
    logic                   r_pwm;
    logic                   r_fsc;
    logic                   r_intb;

    for (genvar g = 0; g < ERR_NUM; g++) begin : g_dbnc
        lv_err_dbnc #(
            .DBNC_CYC (DBNC_CYC)
        ) u_dbnc (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_err[g]),
            .o_filt  (w_filt[g])
        );
    end

    assign w_qual       = w_filt & ~i_err_mask;
    assign w_hard       = w_qual & HARD_MSK;
    assign w_soft       = w_qual & ~HARD_MSK;
    assign w_recov_done = (r_recov_cnt == RECOV_LAST);
    assign w_tmo_hit    = r_req && (r_tmo_cnt == TMO_LAST);

    // Next-state decision; supply loss overrides everything
    always_comb begin
        w_nxt = r_state;
        if (!i_pwr_on) begin
            w_nxt = PWR_DWN_ST;
        end else begin
            case (r_state)
                PWR_DWN_ST:  w_nxt = WAIT_ST;
                WAIT_ST: begin
                    if (r_tmo)
                        w_nxt = LOCK_ST;
                    else if (i_efuse_vld && i_nml_en && !(|w_hard))
                        w_nxt = i_fsenb_n ? NML_ST : FAILSAFE_ST;
                end
                NML_ST: begin
                    if (i_cfg_en)        w_nxt = CFG_ST;
                    else if (|w_hard)    w_nxt = FAULT_ST;
                    else if (!i_fsenb_n) w_nxt = FAILSAFE_ST;
                    else if (|w_soft)    w_nxt = FAULT_ST;
                end
                FAILSAFE_ST: begin
                    if (|w_hard)        w_nxt = FAULT_ST;
                    else if (i_fsenb_n) w_nxt = NML_ST;
                end
                FAULT_ST: begin
                    if (i_cfg_en)                        w_nxt = CFG_ST;
                    else if (r_retry == RETRY_LIM)       w_nxt = LOCK_ST;
                    else if (!(|w_hard) && !i_fsenb_n)   w_nxt = FAILSAFE_ST;
                    else if (w_recov_done && i_fsenb_n)  w_nxt = NML_ST;
                end
                CFG_ST: begin
                    if (!i_cfg_en) w_nxt = FAULT_ST;
                end
                LOCK_ST:     w_nxt = LOCK_ST;
                default:     w_nxt = PWR_DWN_ST;
            endcase
        end
    end

    // State register plus enables registered from next state so they move with o_cur_st
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PWR_DWN_ST;
            r_pwm   <= 1'b0;
            r_fsc   <= 1'b0;
            r_intb  <= 1'b1;
        end else begin
            r_state <= w_nxt;
            r_pwm   <= (w_nxt == NML_ST);
            r_fsc   <= (w_nxt == FAILSAFE_ST);
            r_intb  <= !(st_forces_int(w_nxt) || ((w_nxt == CFG_ST) && (|r_sticky)));
        end
    end

    // Sticky error capture; a new qualified error beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sticky <= '0;
        else          r_sticky <= (r_sticky & ~i_err_clr) | w_qual;
    end

    // Fault-entry count: cleared on power-down and on entering config, saturates at the limit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_retry <= '0;
        else if ((r_state == PWR_DWN_ST) || ((w_nxt == CFG_ST) && (r_state != CFG_ST)))
            r_retry <= '0;
        else if (((r_state == NML_ST) || (r_state == FAILSAFE_ST)) && (w_nxt == FAULT_ST)
                 && (r_retry != RETRY_LIM))
            r_retry <= r_retry + 1'b1;
    end

    // Error-free run length while staying in FAULT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_recov_cnt <= '0;
        else if ((r_state != FAULT_ST) || (w_nxt != FAULT_ST) || (|w_qual))
            r_recov_cnt <= '0;
        else if (!w_recov_done)
            r_recov_cnt <= r_recov_cnt + 1'b1;
    end

    // Efuse load request with timeout; the timeout flag survives until power-down
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req     <= 1'b0;
            r_tmo     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_req ? r_tmo_cnt + 1'b1 : '0;
            if (r_state == PWR_DWN_ST) r_tmo <= 1'b0;
            else if (w_tmo_hit)        r_tmo <= 1'b1;
            if ((w_nxt != WAIT_ST) || w_tmo_hit || i_efuse_load_done)
                r_req <= 1'b0;
            else if ((r_state == WAIT_ST) && !i_efuse_vld)
                r_req <= 1'b1;
        end
    end

`ifdef LV_CTRL_FIRST_ERR_EN
    localparam int IDX_W = (ERR_NUM > 1) ? $clog2(ERR_NUM) : 1;

    logic [ERR_NUM-1:0] r_qual_d;
    logic [ERR_NUM-1:0] w_rise;
    logic [IDX_W-1:0]   w_rise_idx;
    logic [IDX_W-1:0]   r_first_idx;
    logic               r_first_vld;

    assign w_rise = w_qual & ~r_qual_d;

    // Lowest rising index: scan downward so the lowest set bit is written last
    always_comb begin
        w_rise_idx = '0;
        for (int i = ERR_NUM - 1; i >= 0; i--) begin
            if (w_rise[i]) w_rise_idx = IDX_W'(i);
        end
    end

    // Hold the first qualified error until config is left or power goes down
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qual_d    <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_qual_d <= w_qual;
            if ((r_state == PWR_DWN_ST) || ((r_state == CFG_ST) && (w_nxt != CFG_ST))) begin
                r_first_idx <= '0;
                r_first_vld <= 1'b0;
            end else if (!r_first_vld && (|w_rise)) begin
                r_first_idx <= w_rise_idx;
                r_first_vld <= 1'b1;
            end
        end
    end

    assign o_first_err_idx = r_first_idx;
    assign o_first_err_vld = r_first_vld;
`endif

    assign o_cur_st         = r_state;
    assign o_pwm_en         = r_pwm;
    assign o_fsc_en         = r_fsc;
    assign o_intb_n         = r_intb;
    assign o_err_qual       = w_qual;
    assign o_err_sticky     = r_sticky;
    assign o_retry_cnt      = r_retry;
    assign o_efuse_load_req = r_req;
    assign o_efuse_tmo      = r_tmo;

endmodule

// File: tb/tb_lv_ctrl_fsm_gen.sv
// tb/tb_lv_ctrl_fsm_gen.sv - directed bench with a cycle model for lv_ctrl_fsm_gen
`timescale 1ns/1ps
module tb_lv_ctrl_fsm_gen;
    import lv_ctrl_pkg::*;

    localparam int          N     = 16;
    localparam logic [N-1:0] HARD = 16'h00FF;
    localparam int          DBNC  = 4;
    localparam int          RECOV = 32;
    localparam int          RMAX  = 3;
    localparam int          TMO   = 1024;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         pwr_on    = 1'b0;
    logic [N-1:0] err       = '0;
    logic [N-1:0] mask      = '0;
    logic [N-1:0] clr       = '0;
    logic         fsenb_n   = 1'b1;
    logic         nml_en    = 1'b0;
    logic         cfg_en    = 1'b0;
    logic         efuse_vld = 1'b0;
    logic         load_done = 1'b0;

    logic         efuse_req, pwm_en, fsc_en, intb_n, efuse_tmo;
    logic [N-1:0] qual, sticky;
    logic [3:0]   retry;
    logic [2:0]   cur_st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lv_ctrl_fsm_gen dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pwr_on          (pwr_on),
        .i_err             (err),
        .i_err_mask        (mask),
        .i_err_clr         (clr),
        .i_fsenb_n         (fsenb_n),
        .i_nml_en          (nml_en),
        .i_cfg_en          (cfg_en),
        .i_efuse_vld       (efuse_vld),
        .o_efuse_load_req  (efuse_req),
        .i_efuse_load_done (load_done),
        .o_pwm_en          (pwm_en),
        .o_fsc_en          (fsc_en),
        .o_intb_n          (intb_n),
        .o_err_qual        (qual),
        .o_err_sticky      (sticky),
        .o_retry_cnt       (retry),
        .o_efuse_tmo       (efuse_tmo),
        .o_cur_st          (cur_st)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ctrl_st_e     m_st     = PWR_DWN_ST;
    logic [N-1:0] m_filt   = '0;
    logic [N-1:0] m_prev   = '0;
    logic [N-1:0] m_sticky = '0;
    int           m_run[N];
    int           m_retry  = 0;
    int           m_recov  = 0;
    int           m_age    = 0;
    logic         m_req    = 1'b0;
    logic         m_tmo    = 1'b0;
    logic         m_pwm    = 1'b0;
    logic         m_fsc    = 1'b0;
    logic         m_intb   = 1'b1;

    function automatic ctrl_st_e model_next(input logic [N-1:0] q);
        bit any_hard;
        bit any_soft;
        bit done;
        any_hard = ($countones(q & HARD) != 0);
        any_soft = ($countones(q & ~HARD) != 0);
        done     = (m_recov >= RECOV - 1);
        if (!pwr_on) return PWR_DWN_ST;
        case (m_st)
            PWR_DWN_ST: return WAIT_ST;
            WAIT_ST: begin
                if (m_tmo) return LOCK_ST;
                if (efuse_vld && nml_en && !any_hard) return fsenb_n ? NML_ST : FAILSAFE_ST;
                return WAIT_ST;
            end
            NML_ST: begin
                if (cfg_en)   return CFG_ST;
                if (any_hard) return FAULT_ST;
                if (!fsenb_n) return FAILSAFE_ST;
                if (any_soft) return FAULT_ST;
                return NML_ST;
            end
            FAILSAFE_ST: begin
                if (any_hard) return FAULT_ST;
                if (fsenb_n)  return NML_ST;
                return FAILSAFE_ST;
            end
            FAULT_ST: begin
                if (cfg_en)                 return CFG_ST;
                if (m_retry == RMAX)        return LOCK_ST;
                if (!any_hard && !fsenb_n)  return FAILSAFE_ST;
                if (done && fsenb_n)        return NML_ST;
                return FAULT_ST;
            end
            CFG_ST:  return cfg_en ? CFG_ST : FAULT_ST;
            LOCK_ST: return LOCK_ST;
            default: return PWR_DWN_ST;
        endcase
    endfunction

    task automatic model_step();
        logic [N-1:0] q;
        ctrl_st_e     nx;
        bit           hit;
        if (!rst_n) begin
            m_st = PWR_DWN_ST; m_filt = '0; m_prev = '0; m_sticky = '0;
            for (int b = 0; b < N; b++) m_run[b] = 0;
            m_retry = 0; m_recov = 0; m_age = 0;
            m_req = 0; m_tmo = 0; m_pwm = 0; m_fsc = 0; m_intb = 1;
            return;
        end
        q  = m_filt & ~mask;
        nx = model_next(q);
        m_pwm  = (nx == NML_ST);
        m_fsc  = (nx == FAILSAFE_ST);
        m_intb = !((nx inside {PWR_DWN_ST, WAIT_ST, FAULT_ST, LOCK_ST}) || (nx == CFG_ST && m_sticky != 0));
        if (m_st == PWR_DWN_ST) m_retry = 0;
        else if (nx == CFG_ST && m_st != CFG_ST) m_retry = 0;
        else if ((m_st == NML_ST || m_st == FAILSAFE_ST) && nx == FAULT_ST && m_retry < RMAX) m_retry++;
        if (m_st == FAULT_ST && nx == FAULT_ST && q == 0) m_recov++;
        else m_recov = 0;
        hit = 0;
        if (m_req) begin
            m_age++;
            hit = (m_age == TMO);
        end
        if (m_st == PWR_DWN_ST) m_tmo = 0;
        else if (hit) m_tmo = 1;
        if (nx != WAIT_ST || hit || load_done) m_req = 0;
        else if (m_st == WAIT_ST && !efuse_vld) m_req = 1;
        if (!m_req) m_age = 0;
        m_sticky = (m_sticky & ~clr) | q;
        // a level is accepted once it has been seen DBNC samples in a row
        for (int b = 0; b < N; b++) begin
            if (err[b] == m_prev[b]) m_run[b]++;
            else m_run[b] = 1;
            m_prev[b] = err[b];
            if (err[b] != m_filt[b] && m_run[b] >= DBNC) m_filt[b] = err[b];
        end
        m_st = nx;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(posedge clk);
            #3;
            chk("cur_st", cur_st, m_st);
            chk("pwm_en", pwm_en, m_pwm);
            chk("fsc_en", fsc_en, m_fsc);
            chk("intb_n", intb_n, m_intb);
            chk("err_qual", qual, m_filt & ~mask);
            chk("err_sticky", sticky, m_sticky);
            chk("retry_cnt", retry, m_retry);
            chk("efuse_req", efuse_req, m_req);
            chk("efuse_tmo", efuse_tmo, m_tmo);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        cyc(3);
        chk("rst_state", cur_st, PWR_DWN_ST);
        chk("rst_intb", intb_n, 1);
        chk("rst_pwm", pwm_en, 0);
        chk("rst_retry", retry, 0);
        rst_n = 1'b1;
        cyc(1);
        chk("pdn_intb", intb_n, 0);

        // power-up
        pwr_on = 1; efuse_vld = 1; nml_en = 1;
        cyc(1); chk("pu_wait", cur_st, WAIT_ST);
        cyc(1); chk("pu_nml", cur_st, NML_ST);
        chk("pu_pwm", pwm_en, 1);
        chk("pu_intb", intb_n, 1);

        // debounce: 3 cycles rejected, 4 cycles accepted
        err[9] = 1; cyc(3);
        chk("dbnc3_qual", qual, 16'h0000);
        err[9] = 0; cyc(2);
        chk("dbnc3_st", cur_st, NML_ST);
        err[9] = 1; cyc(4);
        chk("dbnc4_qual", qual, 16'h0200);
        chk("dbnc4_st", cur_st, NML_ST);
        cyc(1);
        chk("flt_st", cur_st, FAULT_ST);
        chk("flt_pwm", pwm_en, 0);
        chk("flt_retry", retry, 1);
        chk("flt_intb", intb_n, 0);

        // recovery: 4 debounce + 32 error-free cycles
        err = '0; cyc(35);
        chk("recov_pre", cur_st, FAULT_ST);
        cyc(1);
        chk("recov_nml", cur_st, NML_ST);
        chk("recov_pwm", pwm_en, 1);

        // two more fault entries reach the retry limit
        for (int k = 2; k <= 3; k++) begin
            err[9] = 1; cyc(5);
            chk("lock_flt", cur_st, FAULT_ST);
            chk("lock_retry", retry, k);
            err[9] = 0;
            if (k < 3) begin
                cyc(36);
                chk("lock_back", cur_st, NML_ST);
            end
        end
        cyc(1); chk("lock_st", cur_st, LOCK_ST);
        cyc(40); cfg_en = 1; cyc(3);
        chk("lock_hold", cur_st, LOCK_ST);
        cfg_en = 0; pwr_on = 0;
        cyc(1); chk("lock_exit", cur_st, PWR_DWN_ST);
        chk("lock_exit_retry", retry, 3);
        cyc(1); chk("pdn_retry_clr", retry, 0);

        // failsafe with soft error, then hard error forces FAULT
        pwr_on = 1; cyc(2);
        chk("fs_pre", cur_st, NML_ST);
        fsenb_n = 0; err[9] = 1; cyc(1);
        chk("fs_st", cur_st, FAILSAFE_ST);
        chk("fs_fsc", fsc_en, 1);
        chk("fs_pwm", pwm_en, 0);
        chk("fs_intb", intb_n, 1);
        cyc(5); chk("fs_soft_hold", cur_st, FAILSAFE_ST);
        err[2] = 1; cyc(5);
        chk("fs_hard_flt", cur_st, FAULT_ST);
        chk("fs_retry", retry, 1);
        chk("fs_fsc_off", fsc_en, 0);

        // masking a hard error keeps NML
        pwr_on = 0; err = '0; fsenb_n = 1; cyc(6);
        pwr_on = 1; cyc(2);
        chk("msk_pre", cur_st, NML_ST);
        mask[2] = 1; err[2] = 1; cyc(8);
        chk("msk_qual", qual, 16'h0000);
        chk("msk_st", cur_st, NML_ST);

        // config entry: interrupt reflects sticky history
        cfg_en = 1; cyc(1);
        chk("cfg_st", cur_st, CFG_ST);
        chk("cfg_intb", intb_n, 0);
        chk("cfg_retry", retry, 0);
        clr = '1; cyc(1); clr = '0; cyc(1);
        chk("cfg_sticky_clr", sticky, 16'h0000);
        chk("cfg_intb_clr", intb_n, 1);
        cfg_en = 0; cyc(1);
        chk("cfg_exit", cur_st, FAULT_ST);

        // efuse timeout
        pwr_on = 0; mask = '0; err = '0; efuse_vld = 0; cyc(6);
        pwr_on = 1; cyc(2);
        chk("ef_st", cur_st, WAIT_ST);
        chk("ef_req", efuse_req, 1);
        cyc(1023);
        chk("ef_req_hold", efuse_req, 1);
        chk("ef_tmo_pre", efuse_tmo, 0);
        cyc(1);
        chk("ef_req_drop", efuse_req, 0);
        chk("ef_tmo", efuse_tmo, 1);
        chk("ef_tmo_st", cur_st, WAIT_ST);
        cyc(1);
        chk("ef_lock", cur_st, LOCK_ST);

        // efuse done handshake
        pwr_on = 0; nml_en = 0; cyc(2);
        chk("ef_tmo_clr", efuse_tmo, 0);
        pwr_on = 1; cyc(12);
        chk("ef_req2", efuse_req, 1);
        load_done = 1; efuse_vld = 1; cyc(1); load_done = 0;
        chk("ef_done", efuse_req, 0);
        cyc(2);
        chk("ef_done_hold", efuse_req, 0);
        chk("ef_done_st", cur_st, WAIT_ST);
        nml_en = 1; cyc(1);
        chk("ef_nml", cur_st, NML_ST);

        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
